// File: rtl/redtin_readout_sequencer.sv
// Readout sequencer for the Red Tin capture core: dumps the frozen buffer MSB-byte-first
// over a byte valid/ready link behind a sync byte, then re-arms the core.
module redtin_readout_sequencer #(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [7:0]  SYNC_BYTE    = 8'h5A
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  la_done,
    input  logic [DATA_WIDTH-1:0] la_read_data,
    output logic [ADDR_WIDTH-1:0] la_read_addr,
    output logic                  la_reset,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam int unsigned CntW     = $clog2(READ_LATENCY + 1);

    localparam logic [ByteW-1:0] LastByte  = ByteW'(NumBytes - 1);
    // Data is sampled on the READ_LATENCY-th edge after the address changes.
    localparam logic [CntW-1:0]  FetchLoad = CntW'(READ_LATENCY - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWait  = 3'd1;
    localparam logic [2:0] StHdr   = 3'd2;
    localparam logic [2:0] StFetch = 3'd3;
    localparam logic [2:0] StSend  = 3'd4;
    localparam logic [2:0] StRearm = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  la_reset_q, la_reset_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [ByteW-1:0]      byte_idx_q, byte_idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  accept;

    assign accept = tx_valid_q & tx_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        la_reset_d = la_reset_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        cnt_d      = cnt_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (la_done) begin
                    state_d    = StHdr;
                    addr_d     = '0;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                end
            end
            StHdr: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    cnt_d      = FetchLoad;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                if (cnt_q == '0) begin
                    shift_d    = la_read_data;
                    tx_data_d  = la_read_data[DATA_WIDTH-1 -: 8];
                    tx_valid_d = 1'b1;
                    byte_idx_d = '0;
                    state_d    = StSend;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSend: begin
                if (accept) begin
                    if (byte_idx_q == LastByte) begin
                        tx_valid_d = 1'b0;
                        if (&addr_q) begin
                            la_reset_d = 1'b1;
                            state_d    = StRearm;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            cnt_d   = FetchLoad;
                            state_d = StFetch;
                        end
                    end else begin
                        shift_d    = shift_q << 8;
                        tx_data_d  = shift_d[DATA_WIDTH-1 -: 8];
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            StRearm: begin
                // Hold the re-arm request until the core acknowledges by dropping done.
                if (!la_done) begin
                    la_reset_d = 1'b0;
                    addr_d     = '0;
                    cnt_d      = '0;
                    state_d    = start ? StWait : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            la_reset_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            la_reset_q <= la_reset_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign la_read_addr = addr_q;
    assign la_reset     = la_reset_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_redtin_readout_sequencer.sv
// Scoreboard bench: a default-sized sequencer and a small one (32-bit samples, 16 deep,
// read latency 3), each fed by a pipelined buffer model.
module tb_redtin_readout_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default instance
    logic         reset, start, la_done, tx_ready, la_reset, tx_valid, busy;
    logic [127:0] la_read_data;
    logic [8:0]   la_read_addr;
    logic [7:0]   tx_data;
    logic [7:0]   q[$];
    int           nacc = 0;
    bit           rnd_mode = 1'b0;

    // Small instance
    logic        s_reset, s_start, s_done, s_tx_ready, s_la_reset, s_tx_valid, s_busy;
    logic [31:0] s_rd_data, s_rd1, s_rd2;
    logic [3:0]  s_addr;
    logic [7:0]  s_tx_data;
    logic [7:0]  s_q[$];
    int          s_nacc = 0;
    int          s_t0 = 0;
    int          s_t1 = 0;

    redtin_readout_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .la_done      (la_done),
        .la_read_data (la_read_data),
        .la_read_addr (la_read_addr),
        .la_reset     (la_reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy)
    );

    redtin_readout_sequencer #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (4),
        .READ_LATENCY (3),
        .SYNC_BYTE    (8'h5A)
    ) dut_s (
        .clk          (clk),
        .reset        (s_reset),
        .start        (s_start),
        .la_done      (s_done),
        .la_read_data (s_rd_data),
        .la_read_addr (s_addr),
        .la_reset     (s_la_reset),
        .tx_data      (s_tx_data),
        .tx_valid     (s_tx_valid),
        .tx_ready     (s_tx_ready),
        .busy         (s_busy)
    );

    function automatic logic [127:0] big_sample(input logic [8:0] a);
        logic [15:0] w;
        w = {7'b0, a};
        return {8{w}};
    endfunction

    function automatic logic [31:0] sm_sample(input logic [3:0] a);
        return {4'hD, a, 4'hB, a, 4'h7, a, 4'h0, a};
    endfunction

    // Buffer models: one register stage at latency 2, two stages at latency 3.
    always @(posedge clk) la_read_data <= big_sample(la_read_addr);
    always @(posedge clk) begin
        s_rd1 <= sm_sample(s_addr);
        s_rd2 <= s_rd1;
    end
    assign s_rd_data = s_rd2;

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rnd_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_big_dump();
        logic [127:0] d;
        q.push_back(8'h5A);
        for (int i = 0; i < 512; i++) begin
            d = big_sample(i[8:0]);
            for (int b = 0; b < 16; b++) q.push_back(d[127-8*b -: 8]);
        end
    endtask

    // Big-instance monitor: byte scoreboard plus hold-while-stalled check.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    always @(negedge clk) begin
        logic [7:0] want;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!tx_valid || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%0b data=%0h expected valid=1 data=%0h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got %0h expected none", tx_data);
                end else begin
                    want = q.pop_front();
                    if (tx_data !== want) begin
                        errors++;
                        $display("FAIL byte_%0d got %0h expected %0h", nacc, tx_data, want);
                    end
                end
                nacc++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    always @(negedge clk) begin
        logic [7:0] want;
        if (!s_reset && s_tx_valid && s_tx_ready) begin
            checks++;
            if (s_q.size() == 0) begin
                errors++;
                $display("FAIL s_unexpected_byte got %0h expected none", s_tx_data);
            end else begin
                want = s_q.pop_front();
                if (s_tx_data !== want) begin
                    errors++;
                    $display("FAIL s_byte_%0d got %0h expected %0h", s_nacc, s_tx_data, want);
                end
            end
            if (s_nacc == 0) s_t0 = cyc;
            if (s_nacc == 64) s_t1 = cyc;
            s_nacc++;
        end
    end

    // Wait for the re-arm pulse, keep la_done high 3 clocks, then release it.
    task automatic big_rearm(input bit exp_busy, input int limit);
        int n;
        bit redump;
        n = 0;
        while (!la_reset && n < limit) begin
            tick(1);
            n++;
        end
        chk("rearm_reached", la_reset, 1);
        chk("dump_drained", q.size(), 0);
        for (int k = 0; k < 4; k++) begin
            chk("la_reset_held", la_reset, 1);
            if (k < 3) tick(1);
        end
        la_done = 1'b0;
        tick(1);
        chk("la_reset_dropped", la_reset, 0);
        chk("addr_cleared", la_read_addr, 0);
        redump = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (tx_valid) redump = 1'b1;
        end
        chk("no_redump", redump, 0);
        chk("busy_after_rearm", busy, exp_busy);
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b1; start = 1'b0; la_done = 1'b0;
        s_reset = 1'b1; s_start = 1'b0; s_done = 1'b0; s_tx_ready = 1'b1;
        tick(3);
        chk("rst_addr", la_read_addr, 0);
        chk("rst_la_reset", la_reset, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("s_rst_busy", s_busy, 0);
        chk("s_rst_tx_valid", s_tx_valid, 0);
        reset = 1'b0;
        s_reset = 1'b0;
        tick(2);
        chk("idle_busy", busy, 0);

        // Small instance: 65 bytes, 7 clocks per sample with tx_ready tied high.
        s_q.push_back(8'h5A);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = sm_sample(i[3:0]);
            for (int b = 0; b < 4; b++) s_q.push_back(d[31-8*b -: 8]);
        end
        s_start = 1'b1;
        tick(3);
        s_done = 1'b1;
        n = 0;
        while (!s_la_reset && n < 500) begin
            tick(1);
            n++;
        end
        chk("s_rearm_reached", s_la_reset, 1);
        chk("s_drained", s_q.size(), 0);
        chk("s_byte_count", s_nacc, 65);
        chk("s_cycles_16_samples", s_t1 - s_t0, 16 * 7);
        s_start = 1'b0;
        s_done = 1'b0;
        tick(1);
        chk("s_la_reset_dropped", s_la_reset, 0);
        chk("s_idle_busy", s_busy, 0);

        // Default instance, tx_ready tied high, la_done after 10 clocks.
        push_big_dump();
        base = nacc;
        start = 1'b1;
        tick(10);
        chk("wait_busy", busy, 1);
        chk("wait_no_valid", tx_valid, 0);
        la_done = 1'b1;
        big_rearm(1'b1, 12000);
        chk("dump1_bytes", nacc - base, 8193);

        // Random 30% ready duty, same stream.
        rnd_mode = 1'b1;
        push_big_dump();
        base = nacc;
        la_done = 1'b1;
        big_rearm(1'b1, 40000);
        chk("dump2_bytes", nacc - base, 8193);
        rnd_mode = 1'b0;

        // Reset at byte 4000, then a fresh dump during which start drops.
        push_big_dump();
        base = nacc;
        la_done = 1'b1;
        n = 0;
        while (nacc - base < 4000 && n < 6000) begin
            tick(1);
            n++;
        end
        chk("reached_4000", (nacc - base >= 4000), 1);
        reset = 1'b1;
        #1;
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_addr", la_read_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_la_reset", la_reset, 0);
        q.delete();
        tick(3);
        push_big_dump();
        base = nacc;
        reset = 1'b0;
        n = 0;
        while (nacc - base < 200 && n < 1000) begin
            tick(1);
            n++;
        end
        chk("fresh_dump_started", (nacc - base >= 200), 1);
        start = 1'b0;
        big_rearm(1'b0, 12000);
        chk("dump4_bytes", nacc - base, 8193);
        chk("final_idle_valid", tx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
